// File: rtl/alu_op_sequencer_pkg.sv
// Shared constants for alu_op_sequencer: ALU op codes, FSM states, RV32I/M field values.
package alu_op_sequencer_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_NOP  = 4'd15;

  typedef enum logic [2:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX, ST_DONE} state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_ZERO   = 7'b0000000;

  localparam logic [6:0] F7_BASE  = 7'b0000000;
  localparam logic [6:0] F7_ALT   = 7'b0100000;
  localparam logic [6:0] M_FUNCT7 = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // funct3 -> ALU op ignoring funct7 (ADD and SRL are the unmodified forms)
  function automatic logic [3:0] f3_to_alu(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_sequencer_muldiv_iter.sv
// Iterative RV32M engine: shift-add multiply / restoring divide on magnitudes, sign fix on output.
// Divider datapath present only when ALU_SEQ_DIV_EN is defined.
module muldiv_iter
  import alu_op_sequencer_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN);

  // acc: {spare, high word (partial product / remainder), low word (multiplier / quotient)}
  logic [2*XLEN:0]  acc_reg;
  logic [XLEN-1:0]  opnd_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       op_reg;
  logic             active_reg, neg_reg;
`ifdef ALU_SEQ_DIV_EN
  logic             rneg_reg, dz_reg;
`endif

  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   mul_sum;
  logic [2*XLEN:0] step;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] mul_res;

  always_comb begin
    a_neg = a[XLEN-1] && (op == F3_MULH || op == F3_MULHSU || op == F3_DIV || op == F3_REM);
    b_neg = b[XLEN-1] && (op == F3_MULH || op == F3_DIV || op == F3_REM);
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

`ifdef ALU_SEQ_DIV_EN
  logic [XLEN:0]   rem_sh, rem_new;
  logic            ge;
  logic [XLEN-1:0] quo, rem;
`endif

  always_comb begin
    mul_sum = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
    step    = {1'b0, mul_sum, acc_reg[XLEN-1:1]};
`ifdef ALU_SEQ_DIV_EN
    rem_sh  = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
    ge      = rem_sh >= {1'b0, opnd_reg};
    rem_new = ge ? rem_sh - {1'b0, opnd_reg} : rem_sh;
    if (op_reg[2]) step = {1'b0, rem_new[XLEN-1:0], acc_reg[XLEN-2:0], ge};
`endif
  end

  always_comb begin
    prod    = neg_reg ? -acc_reg[2*XLEN-1:0] : acc_reg[2*XLEN-1:0];
    mul_res = (op_reg == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    result  = mul_res;
`ifdef ALU_SEQ_DIV_EN
    quo = dz_reg ? '1 : (neg_reg ? -acc_reg[XLEN-1:0] : acc_reg[XLEN-1:0]);
    rem = rneg_reg ? -acc_reg[2*XLEN-1:XLEN] : acc_reg[2*XLEN-1:XLEN];
    if (op_reg[2]) result = op_reg[1] ? rem : quo;
`endif
  end

  assign done = active_reg && (cnt_reg == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg    <= '0;
      opnd_reg   <= '0;
      cnt_reg    <= '0;
      op_reg     <= '0;
      active_reg <= 1'b0;
      neg_reg    <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      rneg_reg   <= 1'b0;
      dz_reg     <= 1'b0;
`endif
    end else if (kill) begin
      active_reg <= 1'b0;
      cnt_reg    <= '0;
    end else if (start) begin
      op_reg     <= op;
      active_reg <= 1'b1;
      cnt_reg    <= '0;
      opnd_reg   <= op[2] ? b_mag : a_mag;
      acc_reg    <= {1'b0, {XLEN{1'b0}}, (op[2] ? a_mag : b_mag)};
      neg_reg    <= a_neg ^ b_neg;
`ifdef ALU_SEQ_DIV_EN
      rneg_reg   <= a_neg;
      dz_reg     <= (b == '0);
`endif
    end else if (active_reg && cnt_reg != CNT_LAST) begin
      acc_reg <= step;
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Registered, handshaked ALU op decode with an iterative RV32M engine behind it.
// ALU_SEQ_DIV_EN enables DIV/DIVU/REM/REMU; otherwise they decode as illegal.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_alu_ctrl,
  output logic            out_is_muldiv,
  output logic [XLEN-1:0] out_result,
  output logic            out_illegal,
  output logic            busy
);

  state_e          state_reg, state_next;
  logic [6:0]      opc, f7;
  logic [2:0]      f3;
  logic [3:0]      dec_ctrl;
  logic            dec_illegal, dec_m, accept, eng_done;
  logic [XLEN-1:0] eng_result;
  logic            valid_reg, is_m_reg, illegal_reg;
  logic [3:0]      ctrl_reg;
  logic [XLEN-1:0] result_reg;

  assign opc = instruction[6:0];
  assign f3  = instruction[14:12];
  assign f7  = instruction[31:25];

  always_comb begin
    dec_ctrl    = ALU_NOP;
    dec_illegal = 1'b0;
    dec_m       = 1'b0;
    case (opc)
      OPC_OP: begin
        if (f7 == M_FUNCT7) begin
`ifdef ALU_SEQ_DIV_EN
          dec_m = 1'b1;
`else
          dec_m       = !f3[2];
          dec_illegal = f3[2];
`endif
        end else if (f7 == F7_BASE)                 dec_ctrl = f3_to_alu(f3);
        else if (f7 == F7_ALT && f3 == 3'b000)      dec_ctrl = ALU_SUB;
        else if (f7 == F7_ALT && f3 == 3'b101)      dec_ctrl = ALU_SRA;
        else                                        dec_illegal = 1'b1;
      end
      // Only the shift-immediates carry a funct7; other I-types use those bits as immediate
      OPC_OP_IMM: begin
        if (f3 == 3'b001 && f7 != F7_BASE)          dec_illegal = 1'b1;
        else if (f3 == 3'b101 && f7 == F7_ALT)      dec_ctrl = ALU_SRA;
        else if (f3 == 3'b101 && f7 != F7_BASE)     dec_illegal = 1'b1;
        else                                        dec_ctrl = f3_to_alu(f3);
      end
      OPC_LOAD, OPC_STORE, OPC_JALR, OPC_AUIPC:     dec_ctrl = ALU_ADD;
      OPC_BRANCH:                                   dec_ctrl = ALU_SUB;
      OPC_JAL, OPC_LUI, OPC_ZERO:                   dec_ctrl = ALU_NOP;
      default:                                      dec_illegal = 1'b1;
    endcase
  end

  assign in_ready = (state_reg == ST_IDLE) && (!valid_reg || out_ready);
  assign accept   = in_valid && in_ready && !kill;
  assign busy     = (state_reg != ST_IDLE);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept && dec_m) begin
`ifdef ALU_SEQ_DIV_EN
          state_next = f3[2] ? ST_DIV : ST_MUL;
`else
          state_next = ST_MUL;
`endif
        end
      end
`ifdef ALU_SEQ_DIV_EN
      ST_MUL, ST_DIV: if (eng_done) state_next = ST_FIX;
`else
      ST_MUL:         if (eng_done) state_next = ST_FIX;
`endif
      ST_FIX:         state_next = ST_DONE;
      ST_DONE:        if (out_ready) state_next = ST_IDLE;
      default:        state_next = ST_IDLE;
    endcase
    if (kill) state_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Output bundle: loaded by a base-op accept or by the FIX cycle of an M op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg   <= 1'b0;
      ctrl_reg    <= ALU_NOP;
      is_m_reg    <= 1'b0;
      result_reg  <= '0;
      illegal_reg <= 1'b0;
    end else if (kill) begin
      valid_reg <= 1'b0;
    end else if (accept) begin
      valid_reg   <= !dec_m;
      ctrl_reg    <= dec_ctrl;
      is_m_reg    <= 1'b0;
      result_reg  <= '0;
      illegal_reg <= dec_illegal;
    end else if (state_reg == ST_FIX) begin
      valid_reg   <= 1'b1;
      ctrl_reg    <= ALU_NOP;
      is_m_reg    <= 1'b1;
      result_reg  <= eng_result;
      illegal_reg <= 1'b0;
    end else if (valid_reg && out_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign out_valid     = valid_reg;
  assign out_alu_ctrl  = ctrl_reg;
  assign out_is_muldiv = is_m_reg;
  assign out_result    = result_reg;
  assign out_illegal   = illegal_reg;

  muldiv_iter #(.XLEN(XLEN), .CNT_W(CNT_W)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept && dec_m),
    .kill   (kill),
    .op     (f3),
    .a      (rs1_data),
    .b      (rs2_data),
    .done   (eng_done),
    .result (eng_result)
  );

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: stimulus pushes expected bundles, a monitor pops on each handshake.
// Divide expectations follow ALU_SEQ_DIV_EN as defined for the build.
module tb_alu_op_sequencer;
  import alu_op_sequencer_pkg::*;

  typedef struct {
    logic [3:0]  ctrl;
    logic        m;
    logic [31:0] res;
    logic        ill;
  } exp_t;

  logic        clk, rst_n, in_valid, in_ready, kill, out_valid, out_ready;
  logic [31:0] instruction, rs1_data, rs2_data, out_result;
  logic [3:0]  out_alu_ctrl;
  logic        out_is_muldiv, out_illegal, busy;

  int   total = 0, bad = 0, cyc = 0, acc_cyc = 0;
  exp_t sb[$];

  alu_op_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .kill(kill), .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_ctrl(out_alu_ctrl), .out_is_muldiv(out_is_muldiv),
    .out_result(out_result), .out_illegal(out_illegal), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] opc);
    return {f7, 5'd3, 5'd2, f3, 5'd1, opc};
  endfunction

  function automatic exp_t eb(input logic [3:0] c, input logic ill);
    exp_t e;
    e.ctrl = c; e.m = 1'b0; e.res = 32'h0; e.ill = ill;
    return e;
  endfunction

  function automatic exp_t em(input logic [31:0] r);
    exp_t e;
    e.ctrl = ALU_NOP; e.m = 1'b1; e.res = r; e.ill = 1'b0;
    return e;
  endfunction

  // Divide results when the divider is built, otherwise a one-cycle illegal
  function automatic exp_t ed(input logic [31:0] r);
`ifdef ALU_SEQ_DIV_EN
    return em(r);
`else
    return eb(ALU_NOP, 1'b1 | (r == r));
`endif
  endfunction

  task automatic send(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                      input bit push, input exp_t e);
    int n = 0;
    while (!in_ready && n < 200) begin
      in_valid = 1'b0;
      tick();
      n++;
    end
    if (n >= 200) chk("send_wait_in_ready", in_ready, 1);
    instruction = ins; rs1_data = a; rs2_data = b; in_valid = 1'b1;
    if (push) sb.push_back(e);
    tick();
    acc_cyc = cyc;
    $display("issued instr=0x%08h a=0x%08h b=0x%08h at cycle %0d", ins, a, b, acc_cyc);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    chk("drain_queue_empty", sb.size(), 0);
  endtask

  // Monitor: compares on every accepted output bundle
  always @(negedge clk) begin
    #3;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", out_valid, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("out ctrl=%0d m=%0b res=0x%08h ill=%0b at cycle %0d",
                 out_alu_ctrl, out_is_muldiv, out_result, out_illegal, cyc);
        chk("out_alu_ctrl", out_alu_ctrl, e.ctrl);
        chk("out_is_muldiv", out_is_muldiv, e.m);
        chk("out_result", out_result, e.res);
        chk("out_illegal", out_illegal, e.ill);
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_is_muldiv"}, out_is_muldiv, 0);
    chk({tag, "_out_illegal"}, out_illegal, 0);
    chk({tag, "_out_result"}, out_result, 0);
    chk({tag, "_out_alu_ctrl"}, out_alu_ctrl, ALU_NOP);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
  endtask

  initial begin
    logic [31:0] mid_op;
    bit ready_seen;
    int n;
    rst_n = 1'b0; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b1;
    instruction = 32'h0; rs1_data = 32'h0; rs2_data = 32'h0;
    tick(); tick();
    chk_reset_vals("reset");
    rst_n = 1'b1;
    tick();

    // Base decode, back to back
    send(enc(F7_BASE, 3'b000, OPC_OP),     32'd1, 32'd2, 1, eb(ALU_ADD, 0));
    send(enc(F7_ALT,  3'b101, OPC_OP),     32'd1, 32'd2, 1, eb(ALU_SRA, 0));
    send(enc(F7_BASE, 3'b000, OPC_BRANCH), 32'd1, 32'd2, 1, eb(ALU_SUB, 0));
    send(enc(7'h15,   3'b000, OPC_OP_IMM), 32'd1, 32'd2, 1, eb(ALU_ADD, 0));
    send(enc(F7_ALT,  3'b101, OPC_OP_IMM), 32'd1, 32'd2, 1, eb(ALU_SRA, 0));
    send(enc(7'h7F,   3'b111, OPC_OP_IMM), 32'd1, 32'd2, 1, eb(ALU_AND, 0));
    send(enc(F7_ALT,  3'b001, OPC_OP_IMM), 32'd1, 32'd2, 1, eb(ALU_NOP, 1));
    send(enc(F7_BASE, 3'b010, OPC_LOAD),   32'd1, 32'd2, 1, eb(ALU_ADD, 0));
    send(enc(F7_BASE, 3'b000, OPC_LUI),    32'd1, 32'd2, 1, eb(ALU_NOP, 0));
    send(enc(F7_BASE, 3'b000, OPC_JAL),    32'd1, 32'd2, 1, eb(ALU_NOP, 0));
    send(enc(F7_BASE, 3'b000, 7'b1111111), 32'd1, 32'd2, 1, eb(ALU_NOP, 1));
    send(enc(7'h7F,   3'b000, OPC_OP),     32'd1, 32'd2, 1, eb(ALU_NOP, 1));
    send(enc(F7_BASE, 3'b100, OPC_OP),     32'd1, 32'd2, 1, eb(ALU_XOR, 0));
    send(enc(F7_BASE, 3'b011, OPC_OP),     32'd1, 32'd2, 1, eb(ALU_SLTU, 0));
    in_valid = 1'b0;
    drain();

    // MULH latency and in_ready while busy
    send(enc(M_FUNCT7, F3_MULH, OPC_OP), 32'hFFFF_FFFE, 32'd3, 1, em(32'hFFFF_FFFF));
    in_valid = 1'b0;
    ready_seen = 0; n = 0;
    while (!out_valid && n < 100) begin
      if (in_ready) ready_seen = 1;
      tick();
      n++;
    end
    chk("mulh_latency", cyc - acc_cyc, 34);
    chk("mulh_in_ready_low", ready_seen, 0);
    chk("mulh_busy", busy, 1);
    drain();

    send(enc(M_FUNCT7, F3_MUL,    OPC_OP), 32'hFFFF_FFFE, 32'd3,        1, em(32'hFFFF_FFFA));
    send(enc(M_FUNCT7, F3_MULHU,  OPC_OP), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, em(32'hFFFF_FFFE));
    send(enc(M_FUNCT7, F3_MULHSU, OPC_OP), 32'hFFFF_FFFF, 32'd2,        1, em(32'hFFFF_FFFF));
    send(enc(M_FUNCT7, F3_DIV,    OPC_OP), 32'd7,        32'd0,        1, ed(32'hFFFF_FFFF));
    send(enc(M_FUNCT7, F3_REM,    OPC_OP), 32'd7,        32'd0,        1, ed(32'd7));
    send(enc(M_FUNCT7, F3_DIV,    OPC_OP), 32'h8000_0000, 32'hFFFF_FFFF, 1, ed(32'h8000_0000));
    send(enc(M_FUNCT7, F3_REM,    OPC_OP), 32'h8000_0000, 32'hFFFF_FFFF, 1, ed(32'd0));
    send(enc(M_FUNCT7, F3_DIV,    OPC_OP), 32'hFFFF_FFF9, 32'd2,        1, ed(32'hFFFF_FFFD));
    send(enc(M_FUNCT7, F3_REM,    OPC_OP), 32'hFFFF_FFF9, 32'd2,        1, ed(32'hFFFF_FFFF));
    send(enc(M_FUNCT7, F3_DIVU,   OPC_OP), 32'd100,      32'd7,        1, ed(32'd14));
    in_valid = 1'b0;
    drain();

    // Downstream stall: bundle holds, nothing accepted
    out_ready = 1'b0;
    send(enc(F7_BASE, 3'b000, OPC_OP), 32'd5, 32'd6, 1, eb(ALU_ADD, 0));
    instruction = enc(F7_BASE, 3'b100, OPC_OP);
    in_valid = 1'b1;
    sb.push_back(eb(ALU_XOR, 0));
    for (int i = 0; i < 5; i++) begin
      chk("stall_out_valid", out_valid, 1);
      chk("stall_out_alu_ctrl", out_alu_ctrl, ALU_ADD);
      chk("stall_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    drain();

    // Kill part-way through MULHU, then recover with an ADD
    send(enc(M_FUNCT7, F3_MULHU, OPC_OP), 32'h1234_5678, 32'h9ABC_DEF0, 0, em(32'h0));
    in_valid = 1'b0;
    repeat (9) tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    chk("kill_busy", busy, 0);
    chk("kill_out_valid", out_valid, 0);
    chk("kill_in_ready", in_ready, 1);
    send(enc(F7_BASE, 3'b110, OPC_OP), 32'd1, 32'd2, 1, eb(ALU_OR, 0));
    in_valid = 1'b0;
    repeat (40) tick();
    drain();

    // Asynchronous reset mid-operation
`ifdef ALU_SEQ_DIV_EN
    mid_op = enc(M_FUNCT7, F3_DIV, OPC_OP);
`else
    mid_op = enc(M_FUNCT7, F3_MUL, OPC_OP);
`endif
    send(mid_op, 32'd1000, 32'd7, 0, em(32'h0));
    in_valid = 1'b0;
    repeat (5) tick();
    chk("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midreset");
    tick();
    rst_n = 1'b1;
    send(enc(F7_BASE, 3'b000, OPC_STORE), 32'd1, 32'd2, 1, eb(ALU_ADD, 0));
    in_valid = 1'b0;
    repeat (40) tick();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
